// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver timed directly off the system clock with a bit counter.
// Delivers each good byte with a one-cycle rxdone strobe and flags bad stop bits.
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 625,
    parameter int CNT_SIZE     = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rxbyte,
    output logic       rxdone,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT
    } state_t;

    localparam logic [CNT_SIZE-1:0] HALF_LAST = CNT_SIZE'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_SIZE-1:0] BIT_LAST  = CNT_SIZE'(CLKS_PER_BIT - 1);

    state_t              state, state_n;
    logic [CNT_SIZE-1:0] cnt, cnt_n;
    logic [2:0]          bit_idx, bit_idx_n;
    logic [7:0]          shift, shift_n;
    logic [7:0]          rxbyte_n;
    logic                rxdone_n, frame_err_n;
    logic                rx_meta, rx_s;

    // NOTE: idle-high line, so the synchronizer resets to 1 to avoid a false start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt + 1'b1;
        bit_idx_n   = bit_idx;
        shift_n     = shift;
        rxbyte_n    = rxbyte;
        rxdone_n    = 1'b0;
        frame_err_n = 1'b0;

        unique case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = S_START;
            end
            S_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n     = '0;
                    bit_idx_n = 3'd0;
                    state_n   = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n     = '0;
                    shift_n   = {rx_s, shift[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        rxbyte_n = shift;
                        rxdone_n = 1'b1;
                        state_n  = S_IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A held-low line is a break, not a stream of 0x00 frames.
                cnt_n = '0;
                if (rx_s) state_n = S_IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            rxbyte    <= 8'h00;
            rxdone    <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shift     <= shift_n;
            rxbyte    <= rxbyte_n;
            rxdone    <= rxdone_n;
            frame_err <= frame_err_n;
            busy      <= (state_n != S_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1 at 16 clocks per bit: framing, back-to-back,
// glitch rejection, break handling and mid-frame reset.
module tb_uart_rx_8n1;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    localparam int LAT  = HALF + 9 * CPB + 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rxbyte;
    logic       rxdone;
    logic       frame_err;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int busy_cyc = 0;
    int frame_start = 0;
    logic [7:0] done_bytes[$];
    int         done_cycles[$];

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB), .CNT_SIZE(5)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .rxbyte(rxbyte), .rxdone(rxdone), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rxdone) begin
            done_cnt++;
            done_bytes.push_back(rxbyte);
            done_cycles.push_back(cyc);
        end
        if (frame_err) ferr_cnt++;
        if (busy) busy_cyc++;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        frame_start = cyc;
        rx = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(CPB);
        end
        rx = stop_bit;
        wait_cycles(CPB);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        wait_cycles(3);
        n_tests++; if (rxbyte !== 8'h00) begin n_fail++; $display("FAIL reset_rxbyte: got %h expected 00", rxbyte); end
        n_tests++; if (rxdone !== 1'b0) begin n_fail++; $display("FAIL reset_rxdone: got %b expected 0", rxdone); end
        n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        wait_cycles(4);
    endtask

    task automatic test_single();
        int d0, f0, lat;
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(8'h41, 1'b1);
        wait_cycles(CPB);
        n_tests++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL single_pulses: got %0d expected 1", done_cnt - d0); end
        n_tests++; if (rxbyte !== 8'h41) begin n_fail++; $display("FAIL single_rxbyte: got %h expected 41", rxbyte); end
        n_tests++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL single_frame_err: got %0d expected 0", ferr_cnt - f0); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b expected 0", busy); end
        lat = (done_cycles.size() > 0) ? done_cycles[$] - frame_start : -1;
        n_tests++; if (lat < LAT - 1 || lat > LAT + 1) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d +-1", lat, LAT); end
    endtask

    task automatic test_back_to_back();
        int d0, q0, gap;
        logic [7:0] b0, b1;
        d0 = done_cnt;
        q0 = done_bytes.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_cycles(CPB);
        n_tests++; if (done_cnt - d0 !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 2", done_cnt - d0); end
        b0 = (done_bytes.size() > q0) ? done_bytes[q0] : 8'hxx;
        b1 = (done_bytes.size() > q0 + 1) ? done_bytes[q0 + 1] : 8'hxx;
        gap = (done_cycles.size() > q0 + 1) ? done_cycles[q0 + 1] - done_cycles[q0] : -1;
        n_tests++; if (b0 !== 8'h00) begin n_fail++; $display("FAIL b2b_first_byte: got %h expected 00", b0); end
        n_tests++; if (b1 !== 8'hFF) begin n_fail++; $display("FAIL b2b_second_byte: got %h expected ff", b1); end
        n_tests++; if (gap < 10 * CPB - 1 || gap > 10 * CPB + 1) begin n_fail++; $display("FAIL b2b_gap: got %0d expected %0d +-1", gap, 10 * CPB); end
    endtask

    task automatic test_glitch();
        int d0, f0;
        d0 = done_cnt;
        f0 = ferr_cnt;
        busy_cyc = 0;
        rx = 1'b0;
        wait_cycles(4);
        rx = 1'b1;
        wait_cycles(2 * CPB);
        n_tests++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL glitch_rxdone: got %0d expected 0", done_cnt - d0); end
        n_tests++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL glitch_frame_err: got %0d expected 0", ferr_cnt - f0); end
        n_tests++; if (busy_cyc < 1 || busy_cyc > HALF + 3) begin n_fail++; $display("FAIL glitch_busy_len: got %0d expected 1..%0d", busy_cyc, HALF + 3); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_break();
        int d0, f0;
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(8'hA5, 1'b0);
        wait_cycles(48);
        n_tests++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL break_frame_err: got %0d expected 1", ferr_cnt - f0); end
        n_tests++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL break_rxdone: got %0d expected 0", done_cnt - d0); end
        n_tests++; if (rxbyte !== 8'hFF) begin n_fail++; $display("FAIL break_rxbyte_held: got %h expected ff", rxbyte); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL break_busy_wait: got %b expected 1", busy); end
        rx = 1'b1;
        wait_cycles(CPB);
        send_frame(8'h5A, 1'b1);
        wait_cycles(CPB);
        n_tests++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL break_recover_pulses: got %0d expected 1", done_cnt - d0); end
        n_tests++; if (rxbyte !== 8'h5A) begin n_fail++; $display("FAIL break_recover_rxbyte: got %h expected 5a", rxbyte); end
        n_tests++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL break_single_err: got %0d expected 1", ferr_cnt - f0); end
    endtask

    task automatic test_reset_mid_frame();
        int d0, f0;
        logic [7:0] b;
        b = 8'h33;
        d0 = done_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            wait_cycles(CPB);
        end
        rx = b[3];
        wait_cycles(HALF);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        rx  = 1'b1;
        n_tests++; if (rxbyte !== 8'h00) begin n_fail++; $display("FAIL midrst_rxbyte: got %h expected 00", rxbyte); end
        n_tests++; if (rxdone !== 1'b0) begin n_fail++; $display("FAIL midrst_rxdone: got %b expected 0", rxdone); end
        n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_frame_err: got %b expected 0", frame_err); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        wait_cycles(2 * CPB);
        n_tests++; if ((done_cnt - d0) + (ferr_cnt - f0) !== 0) begin n_fail++; $display("FAIL midrst_no_pulses: got %0d expected 0", (done_cnt - d0) + (ferr_cnt - f0)); end
        send_frame(8'hC3, 1'b1);
        wait_cycles(CPB);
        n_tests++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL midrst_next_pulses: got %0d expected 1", done_cnt - d0); end
        n_tests++; if (rxbyte !== 8'hC3) begin n_fail++; $display("FAIL midrst_next_rxbyte: got %h expected c3", rxbyte); end
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_break();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
